mpu_matrix_loader: RTL and testbench

//  - Writer side of the MPU packed-matrix interface: takes an 8-bit element stream, row-major, on a valid/ready handshake.
//  - Assembles the stream into the packed 5x5 matrix bus plus a size byte, as consumed by the MPU operation units (det, etc.).
//  - Holds the assembled matrix with mat_valid until the consumer acknowledges it.

---
 rtl/mpu_matrix_loader.sv | 101 ++++++++++
 tb/tb_mpu_matrix_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_loader.sv
// Element-stream writer for the MPU packed 5x5 matrix bus: IDLE -> LOAD -> HOLD.
// Optional MPU_LOADER_ZERO_FILL_EN clears all elements on an accepted start.
module mpu_matrix_loader (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     size_in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_data,
    output logic [0:199]   matrix,
    output logic [7:0]     size,
    output logic           mat_valid,
    input  logic           mat_ack,
    output logic           busy,
    output logic           err
);
    localparam int unsigned DIM = 5;
    localparam int unsigned EW  = 8;
    localparam int unsigned CW  = 3;
    localparam int unsigned AW  = 8;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   row, col;
    logic [AW-1:0]   base;
    logic            size_ok, accept, xfer, last, col_end;

    assign size_ok = (size_in != 8'd0) && (size_in <= 8'(DIM));
    assign col_end = (col == CW'(size - 8'd1));
    assign last    = col_end && (row == CW'(size - 8'd1));
    assign base    = AW'(EW * (DIM * 32'(row) + 32'(col)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake decode
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        accept    = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (start && size_ok) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (in_valid && last) state_nxt = HOLD;
            end
            HOLD: begin
                if (mat_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Matrix storage, element counters and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matrix    <= '0;
            size      <= 8'd0;
            row       <= '0;
            col       <= '0;
            mat_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err       <= (state == IDLE) && start && !size_ok;
            mat_valid <= (state_nxt == HOLD);
            if (accept) begin
                size <= size_in;
                row  <= '0;
                col  <= '0;
`ifdef MPU_LOADER_ZERO_FILL_EN
                matrix <= '0;
`endif
            end
            if (xfer) begin
                matrix[base +: EW] <= in_data;
                if (last) begin
                    row <= '0;
                    col <= '0;
                end else if (col_end) begin
                    row <= row + CW'(1);
                    col <= '0;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader against a row-major array model.
module tb_mpu_matrix_loader;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   size_in;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [0:199] matrix;
    logic [7:0]   size;
    logic         mat_valid;
    logic         mat_ack;
    logic         busy;
    logic         err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [5][5];
    logic [7:0] model_size;

    mpu_matrix_loader dut (
        .clk(clk), .rst(rst), .start(start), .size_in(size_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .matrix(matrix), .size(size), .mat_valid(mat_valid),
        .mat_ack(mat_ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:199] pack_model();
        logic [0:199] v;
        v = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                v[8*(c+5*r) +: 8] = model[r][c];
        return v;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                model[r][c] = 8'd0;
    endtask

    // Start a load of n*n values; optionally insert random idle cycles on in_valid
    task automatic do_load(input int n, input logic [7:0] vals[$], input bit gaps);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        start   = 1'b1;
        size_in = 8'(n);
        step();
        start = 1'b0;
        model_size = 8'(n);
`ifdef MPU_LOADER_ZERO_FILL_EN
        clear_model();
`endif
        chk("load_busy", 200'(busy), 200'(1));
        while (got < n*n && cyc < 2000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? vals[got] : 8'($urandom);
            chk("load_in_ready", 200'(in_ready), 200'(1));
            chk("load_mat_valid", 200'(mat_valid), 200'(0));
            step();
            if (in_valid) begin
                model[got / n][got % n] = vals[got];
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("load_transfer_count", 200'(got), 200'(n*n));
        chk("hold_mat_valid", 200'(mat_valid), 200'(1));
        chk("hold_in_ready", 200'(in_ready), 200'(0));
        chk("hold_size", 200'(size), 200'(model_size));
        chk("hold_matrix", 200'(matrix), 200'(pack_model()));
    endtask

    task automatic do_ack();
        mat_ack = 1'b1;
        step();
        mat_ack = 1'b0;
        chk("ack_mat_valid", 200'(mat_valid), 200'(0));
        chk("ack_busy", 200'(busy), 200'(0));
        chk("ack_matrix_kept", 200'(matrix), 200'(pack_model()));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [0:199] held;
        int n;

        rst = 1'b1; start = 1'b0; size_in = 8'd0; in_valid = 1'b0;
        in_data = 8'd0; mat_ack = 1'b0;
        clear_model();
        model_size = 8'd0;
        #3;
        chk("reset_matrix", 200'(matrix), 200'(0));
        chk("reset_size", 200'(size), 200'(0));
        chk("reset_mat_valid", 200'(mat_valid), 200'(0));
        chk("reset_busy", 200'(busy), 200'(0));
        chk("reset_in_ready", 200'(in_ready), 200'(0));
        chk("reset_err", 200'(err), 200'(0));
        step();
        rst = 1'b0;
        step();

        // 2x2 gapless load
        q = {8'd1, 8'd2, 8'd3, 8'd4};
        do_load(2, q, 1'b0);
        chk("t1_e00", 200'(matrix[0 +: 8]), 200'(1));
        chk("t1_e01", 200'(matrix[8 +: 8]), 200'(2));
        chk("t1_e10", 200'(matrix[40 +: 8]), 200'(3));
        chk("t1_e11", 200'(matrix[48 +: 8]), 200'(4));
        chk("t1_size", 200'(size), 200'(2));
        do_ack();

        // 3x3 with random gaps
        q = {};
        for (int i = 1; i <= 9; i++) q.push_back(8'(i));
        do_load(3, q, 1'b1);
        chk("t2_e22", 200'(matrix[96 +: 8]), 200'(9));
        chk("t2_e10", 200'(matrix[40 +: 8]), 200'(4));
        do_ack();

        // Illegal sizes pulse err for one cycle and never leave IDLE
        for (int k = 0; k < 4; k++) begin
            start   = 1'b1;
            size_in = (k == 0) ? 8'd0 : (k == 1) ? 8'd6 : 8'($urandom_range(6, 255));
            step();
            start = 1'b0;
            chk("illegal_err_pulse", 200'(err), 200'(1));
            chk("illegal_busy", 200'(busy), 200'(0));
            chk("illegal_in_ready", 200'(in_ready), 200'(0));
            step();
            chk("illegal_err_drop", 200'(err), 200'(0));
            chk("illegal_busy2", 200'(busy), 200'(0));
            chk("illegal_matrix_kept", 200'(matrix), 200'(pack_model()));
            chk("illegal_size_kept", 200'(size), 200'(model_size));
        end

        // HOLD ignores in_valid and start until acked
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        do_load(4, q, 1'b1);
        held = pack_model();
        in_valid = 1'b1; start = 1'b1; size_in = 8'd3;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'($urandom);
            step();
            chk("stall_mat_valid", 200'(mat_valid), 200'(1));
            chk("stall_in_ready", 200'(in_ready), 200'(0));
            chk("stall_err", 200'(err), 200'(0));
            chk("stall_matrix", 200'(matrix), 200'(held));
        end
        mat_ack = 1'b1;
        step();
        mat_ack = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("stall_ack_mat_valid", 200'(mat_valid), 200'(0));
        chk("stall_ack_busy", 200'(busy), 200'(0));
        chk("stall_ack_err", 200'(err), 200'(0));

        // 5x5 of 0xFF then 2x2 of 1s: outside region depends on zero fill
        q = {};
        for (int i = 0; i < 25; i++) q.push_back(8'hFF);
        do_load(5, q, 1'b0);
        do_ack();
        q = {8'd1, 8'd1, 8'd1, 8'd1};
        do_load(2, q, 1'b1);
`ifdef MPU_LOADER_ZERO_FILL_EN
        chk("fill_e44", 200'(matrix[192 +: 8]), 200'(8'h00));
        chk("fill_e02", 200'(matrix[16 +: 8]), 200'(8'h00));
`else
        chk("fill_e44", 200'(matrix[192 +: 8]), 200'(8'hFF));
        chk("fill_e02", 200'(matrix[16 +: 8]), 200'(8'hFF));
`endif
        do_ack();

        // Random loads
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 5);
            q = {};
            for (int i = 0; i < n*n; i++) q.push_back(8'($urandom));
            do_load(n, q, 1'($urandom_range(0, 1)));
            do_ack();
        end

        // Async reset mid-load after 3 of 9 transfers
        start = 1'b1; size_in = 8'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(i + 20);
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_matrix", 200'(matrix), 200'(0));
        chk("midrst_size", 200'(size), 200'(0));
        chk("midrst_busy", 200'(busy), 200'(0));
        chk("midrst_in_ready", 200'(in_ready), 200'(0));
        chk("midrst_mat_valid", 200'(mat_valid), 200'(0));
        clear_model();
        model_size = 8'd0;
        step();
        rst = 1'b0;
        step();
        q = {8'd5, 8'd6, 8'd7, 8'd8};
        do_load(2, q, 1'b0);
        chk("postrst_e00", 200'(matrix[0 +: 8]), 200'(5));
        do_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
